// File: rtl/line_fetch.sv
// Ping-pong line buffer: prefetch the next visible line over a req/ack read port while streaming the current one.
// Display path is 1 clock from hpos/vpos/disp_en/syncs to rgb/de/hsync/vsync; memory stalls simply hold mem_addr until acked.
module line_fetch #(
   parameter int H_DISPLAY = 480,
   parameter int V_DISPLAY = 272,
   parameter int PIX_W     = 16,
   parameter int ADDR_W    = 17
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic [16:0]       hpos,
   input  logic [16:0]       vpos,
   input  logic              disp_en,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              newline,
   input  logic              newframe,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [PIX_W-1:0]  mem_data,
   output logic [PIX_W-1:0]  rgb,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              underrun
);

   localparam int COL_W  = $clog2(H_DISPLAY);
   localparam int LINE_W = $clog2(V_DISPLAY);
   localparam int BUF_W  = $clog2(2 * H_DISPLAY);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FETCH = 1'b1;

   logic [0:0]        state;
   logic [COL_W-1:0]  col;
   logic [LINE_W-1:0] target;
   logic              discard;
   logic              primed;

   logic              trig;
   logic [LINE_W-1:0] trig_line;
   logic [ADDR_W-1:0] trig_base;
   logic [ADDR_W-1:0] target_base;
   logic              last_col;

   logic [PIX_W-1:0]  line_buf [2*H_DISPLAY];
   logic [PIX_W-1:0]  rd_dat;
   logic              wr_en;
   logic [BUF_W-1:0]  wr_idx;
   logic              rd_en;
   logic [BUF_W-1:0]  rd_idx;

   // newframe is redundant with newline && vpos==0 here
   logic unused_in;
   assign unused_in = newframe;

   always_comb begin
      trig      = 1'b0;
      trig_line = '0;
      if (newline) begin
         if (vpos < 17'(V_DISPLAY - 1)) begin
            trig      = 1'b1;
            trig_line = LINE_W'(vpos + 17'd1);
         end else if (vpos == 17'(V_DISPLAY)) begin
            trig      = 1'b1;
            trig_line = '0;
         end
      end
   end

   assign trig_base   = ADDR_W'(trig_line) * ADDR_W'(H_DISPLAY);
   assign target_base = ADDR_W'(target) * ADDR_W'(H_DISPLAY);
   assign last_col    = (col == COL_W'(H_DISPLAY - 1));
   assign mem_req     = (state == ST_FETCH);

   // A trigger mid-fetch retargets at once; the beat already on the bus is acked and dropped
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         col      <= '0;
         target   <= '0;
         mem_addr <= '0;
         discard  <= 1'b0;
         primed   <= 1'b0;
         underrun <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (trig) begin
            state    <= ST_FETCH;
            col      <= '0;
            target   <= trig_line;
            mem_addr <= trig_base;
         end
      end else begin
         if (trig) begin
            underrun <= 1'b1;
            target   <= trig_line;
            if (mem_ack) begin
               col      <= '0;
               mem_addr <= trig_base;
               discard  <= 1'b0;
            end else begin
               discard  <= 1'b1;
            end
         end else if (mem_ack) begin
            if (discard) begin
               col      <= '0;
               mem_addr <= target_base;
               discard  <= 1'b0;
            end else if (last_col) begin
               state <= ST_IDLE;
               if (target == '0)
                  primed <= 1'b1;
            end else begin
               col      <= col + 1'b1;
               mem_addr <= mem_addr + 1'b1;
            end
         end
      end
   end

   assign wr_en  = (state == ST_FETCH) && mem_ack && !discard && !trig;
   assign wr_idx = target[0] ? BUF_W'(H_DISPLAY) + BUF_W'(col) : BUF_W'(col);
   assign rd_en  = disp_en && (hpos < 17'(H_DISPLAY));
   assign rd_idx = vpos[0] ? BUF_W'(H_DISPLAY) + BUF_W'(hpos[COL_W-1:0])
                           : BUF_W'(hpos[COL_W-1:0]);

   // Buffer RAM has no reset; primed gating hides its contents until line 0 lands
   always_ff @(posedge pclk) begin
      if (wr_en)
         line_buf[wr_idx] <= mem_data;
      if (rd_en)
         rd_dat <= line_buf[rd_idx];
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         de    <= 1'b0;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         de    <= disp_en;
         hsync <= hsync_in;
         vsync <= vsync_in;
      end
   end

   assign rgb = (de && primed) ? rd_dat : '0;

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: drives whole 544-clock lines at chosen vpos values with scripted memory ack patterns.
module tb_line_fetch;

   logic        pclk = 1'b0;
   logic        reset = 1'b1;
   logic [16:0] hpos, vpos;
   logic        disp_en, hsync_in, vsync_in, newline, newframe;
   logic        mem_req;
   logic [16:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic [15:0] rgb;
   logic        de, hsync, vsync, underrun;

   int checks = 0;
   int failures = 0;

   always #5 pclk = ~pclk;

   line_fetch dut (
      .pclk     (pclk),
      .reset    (reset),
      .hpos     (hpos),
      .vpos     (vpos),
      .disp_en  (disp_en),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .newline  (newline),
      .newframe (newframe),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_data (mem_data),
      .rgb      (rgb),
      .de       (de),
      .hsync    (hsync),
      .vsync    (vsync),
      .underrun (underrun)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Per-line observations
   int req_cycles, ack_cnt, first_addr, last_ack_addr, seq_bad, hold_bad, drop_bad;
   int falls, rise_h, rise_addr, first_new, stall_bad, stall_seen;
   int hs_bad, vs_bad, de_bad, rgb_nz;
   int cyc = 0;
   logic [15:0] rgb_line [544];

   // Called on a falling edge. mode 1: ack every cycle, 2: every other cycle,
   // 3: every cycle except a 10-cycle hold when mem_addr first equals stall_addr.
   // rst_addr >= 0 asserts reset when mem_addr reaches it and returns early.
   task automatic run_line(input int v, input int mode, input int stall_addr, input int rst_addr);
      logic p_req, p_ack, p_hs, p_vs, p_de;
      int   p_addr, pa, stall_left;
      req_cycles = 0; ack_cnt = 0; first_addr = -1; last_ack_addr = -1; seq_bad = 0;
      hold_bad = 0; drop_bad = 0; falls = 0; rise_h = -1; rise_addr = -1; first_new = -1;
      stall_bad = 0; stall_seen = 0; hs_bad = 0; vs_bad = 0; de_bad = 0; rgb_nz = 0;
      stall_left = 0;
      pa = 0;
      for (int h = 0; h < 544; h++) begin
         if (rst_addr >= 0 && mem_req && int'(mem_addr) == rst_addr) begin
            chk("de_before_reset", int'(de), 1);
            reset = 1'b1;
            #1;
            chk("req_drop_on_reset", int'(mem_req), 0);
            chk("de_drop_on_reset", int'(de), 0);
            chk("rgb_drop_on_reset", int'(rgb), 0);
            return;
         end
         mem_ack = 1'b0;
         if (mem_req) begin
            case (mode)
               1: mem_ack = 1'b1;
               2: mem_ack = cyc[0];
               default: begin
                  if (stall_left > 0) begin
                     stall_left--;
                     if (int'(mem_addr) != stall_addr) stall_bad++;
                  end else if (stall_seen == 0 && int'(mem_addr) == stall_addr) begin
                     stall_seen = 1;
                     stall_left = 9;
                  end else begin
                     mem_ack = 1'b1;
                  end
               end
            endcase
         end
         if (h == 0) pa = int'(mem_addr);
         hpos     = 17'(h);
         vpos     = 17'(v);
         newline  = (h == 0);
         newframe = (h == 0 && v == 0);
         disp_en  = (h < 480 && v < 272);
         hsync_in = (h >= 490 && h < 500);
         vsync_in = (v == 273 && h < 100);
         mem_data = mem_addr[15:0];
         if (mem_ack) begin
            ack_cnt++;
            if (ack_cnt == 1) first_addr = int'(mem_addr);
            else if (int'(mem_addr) != last_ack_addr + 1) seq_bad++;
            last_ack_addr = int'(mem_addr);
         end
         p_req = mem_req; p_ack = mem_ack; p_addr = int'(mem_addr);
         p_hs = hsync_in; p_vs = vsync_in; p_de = disp_en;
         @(posedge pclk);
         @(negedge pclk);
         cyc++;
         if (mem_req) req_cycles++;
         if (mem_req && !p_req && rise_h < 0) begin
            rise_h    = h;
            rise_addr = int'(mem_addr);
         end
         if (p_req && !mem_req) begin
            falls++;
            if (!p_ack) drop_bad++;
         end
         if (p_req && !p_ack && mem_req && int'(mem_addr) != p_addr) hold_bad++;
         if (first_new < 0 && int'(mem_addr) != pa) first_new = int'(mem_addr);
         if (hsync != p_hs) hs_bad++;
         if (vsync != p_vs) vs_bad++;
         if (de != p_de) de_bad++;
         if (rgb != 16'd0) rgb_nz++;
         rgb_line[h] = rgb;
      end
   endtask

   initial begin
      hpos = '0; vpos = 17'd272; disp_en = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
      newline = 1'b1; newframe = 1'b0; mem_ack = 1'b1; mem_data = 16'hffff;
      repeat (3) @(negedge pclk);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_de", int'(de), 0);
      chk("rst_hsync", int'(hsync), 0);
      chk("rst_vsync", int'(vsync), 0);
      chk("rst_underrun", int'(underrun), 0);
      newline = 1'b0; mem_ack = 1'b0; reset = 1'b0;
      @(negedge pclk);
      chk("newline_in_reset_ignored", int'(mem_req), 0);

      // Frame 1 before priming: visible line, no fetch for 271, blank output
      run_line(271, 1, -1, -1);
      chk("no_fetch_271", req_cycles, 0);
      chk("frame1_blank", rgb_nz, 0);
      chk("de_delay_f1", de_bad, 0);
      chk("hsync_delay", hs_bad, 0);
      run_line(273, 1, -1, -1);
      chk("no_fetch_273", req_cycles, 0);
      chk("vsync_delay", vs_bad, 0);

      // Line 0 prefetch during blanking
      run_line(272, 1, -1, -1);
      chk("l0_rise_cycle", rise_h, 0);
      chk("l0_first_addr", rise_addr, 0);
      chk("l0_acks", ack_cnt, 480);
      chk("l0_last_addr", last_ack_addr, 479);
      chk("l0_req_fall_once", falls, 1);
      chk("l0_no_early_drop", drop_bad, 0);

      // vpos=0: fetch line 1 while showing line 0
      run_line(0, 1, -1, -1);
      chk("l1_rise_cycle", rise_h, 0);
      chk("l1_first_addr", first_addr, 480);
      chk("l1_last_addr", last_ack_addr, 959);
      chk("l1_acks", ack_cnt, 480);
      chk("l1_addr_steps", seq_bad, 0);
      chk("l1_req_fall_once", falls, 1);
      chk("l1_no_early_drop", drop_bad, 0);
      chk("l1_req_cycles", req_cycles, 480);
      chk("f2_pix_0_7", int'(rgb_line[7]), 7);
      chk("f2_pix_0_479", int'(rgb_line[479]), 479);
      chk("f2_blank_after_de", int'(rgb_line[480]), 0);

      // Stall at column 100 of the line-5 fetch
      run_line(4, 3, 5 * 480 + 100, -1);
      chk("stall_seen", stall_seen, 1);
      chk("stall_addr_held", stall_bad, 0);
      chk("stall_hold_unacked", hold_bad, 0);
      chk("stall_acks", ack_cnt, 480);
      chk("stall_addr_steps", seq_bad, 0);
      chk("stall_req_fall_once", falls, 1);

      run_line(5, 1, -1, -1);
      chk("f2_pix_5_7", int'(rgb_line[7]), 2407);
      chk("f2_pix_5_0", int'(rgb_line[0]), 2400);
      chk("f2_pix_5_100", int'(rgb_line[100]), 2500);
      chk("no_underrun_yet", int'(underrun), 0);

      // Half-rate memory: line-7 fetch cannot finish before the next newline
      run_line(6, 2, -1, -1);
      chk("slow_hold_unacked", hold_bad, 0);
      run_line(7, 2, -1, -1);
      chk("overrun_underrun_set", int'(underrun), 1);
      chk("overrun_restart_addr", first_new, 8 * 480);
      chk("overrun_hold_unacked", hold_bad, 0);
      chk("overrun_no_early_drop", drop_bad, 0);
      run_line(8, 1, -1, -1);
      chk("underrun_sticky", int'(underrun), 1);

      // Reset in the middle of the line-1 fetch at column 200
      run_line(0, 1, -1, 480 + 200);
      repeat (2) @(negedge pclk);
      reset = 1'b0;
      @(negedge pclk);
      chk("underrun_cleared", int'(underrun), 0);
      chk("req_idle_after_reset", int'(mem_req), 0);
      run_line(0, 1, -1, -1);
      chk("reblank_after_reset", rgb_nz, 0);
      chk("de_delay_after_reset", de_bad, 0);
      chk("fetch_after_reset", ack_cnt, 480);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
